frog_collision_ctrl: RTL and testbench

//  Consumes lane car X positions from the car movers and the frog grid

---
 rtl/frog_collision_ctrl_pkg.sv | 26 ++
 rtl/frog_collision_ctrl_if.sv | 24 ++
 rtl/frog_collision_ctrl_lane_overlap.sv | 23 ++
 rtl/frog_collision_ctrl.sv | 141 ++++++++++++++
 tb/tb_frog_collision_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frog_collision_ctrl_pkg.sv
// Shared constants, FSM state encoding and grid helper for the frog collision controller.
package frog_collision_ctrl_pkg;

  localparam logic [4:0] GRID_W = 5'd20;
  localparam logic [3:0] GRID_H = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Distance from car head to frog along +X, wrapped onto the GRID_W-column ring.
  function automatic logic [5:0] wrap_dist(input logic [4:0] frog_x, input logic [4:0] car_x);
    logic [5:0] diff_s;
    diff_s = {1'b0, frog_x} - {1'b0, car_x};
    if (diff_s[5]) begin
      diff_s = diff_s + {1'b0, GRID_W};
    end else begin
      diff_s = diff_s;
    end
    return diff_s;
  endfunction

endpackage

// File: rtl/frog_collision_ctrl_if.sv
// Game-side bundle of the frog collision controller: frog/car positions in, game status out.
interface frog_collision_ctrl_if #(
  parameter int NUM_LANES = 4
);
  logic                   i_Start;
  logic [4:0]             i_Frog_X;
  logic [3:0]             i_Frog_Y;
  logic [5*NUM_LANES-1:0] i_Car_X;
  logic                   o_Hit;
  logic                   o_Respawn;
  logic [2:0]             o_Lives;
  logic                   o_Game_Over;
  logic                   o_Playing;

  modport master (
    output i_Start, i_Frog_X, i_Frog_Y, i_Car_X,
    input  o_Hit, o_Respawn, o_Lives, o_Game_Over, o_Playing
  );

  modport slave (
    input  i_Start, i_Frog_X, i_Frog_Y, i_Car_X,
    output o_Hit, o_Respawn, o_Lives, o_Game_Over, o_Playing
  );
endinterface

// File: rtl/frog_collision_ctrl_lane_overlap.sv
// Combinational frog/car overlap test for a single lane; off-grid coordinates never match.
module frog_collision_ctrl_lane_overlap
  import frog_collision_ctrl_pkg::*;
#(
  parameter logic [3:0] LANE_ROW  = 4'd3,
  parameter int         CAR_WIDTH = 2
) (
  input  logic [4:0] frog_x,
  input  logic [3:0] frog_y,
  input  logic [4:0] car_x,
  output logic       match
);

  logic in_grid_s;
  logic on_row_s;
  logic covered_s;

  assign in_grid_s = (frog_x < GRID_W) && (car_x < GRID_W);
  assign on_row_s  = (frog_y == LANE_ROW);
  assign covered_s = (wrap_dist(frog_x, car_x) < 6'(CAR_WIDTH));
  assign match     = in_grid_s && on_row_s && covered_s;

endmodule

// File: rtl/frog_collision_ctrl.sv
// Frog collision controller: lane overlap detection, lives, respawn delay and game-over FSM.
// Optional invulnerability window after each respawn is enabled by defining COLLISION_GRACE_EN.
module frog_collision_ctrl
  import frog_collision_ctrl_pkg::*;
#(
  parameter int          NUM_LANES     = 4,
  parameter logic [3:0]  LANE_ROW_BASE = 4'd3,
  parameter int          CAR_WIDTH     = 2,
  parameter logic [2:0]  START_LIVES   = 3'd3,
  parameter logic [23:0] RESPAWN_TICKS = 24'd12_500_000
`ifdef COLLISION_GRACE_EN
  ,
  parameter logic [23:0] GRACE_TICKS   = 24'd25_000_000
`endif
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  frog_collision_ctrl_if.slave  bus
);

  logic [NUM_LANES-1:0] match_s;
  logic                 overlap_s;
  logic                 grace_active_s;

  state_t      state_r,   state_s;
  logic [23:0] cnt_r,     cnt_s;
  logic [2:0]  lives_r,   lives_s;
  logic        hit_r,     hit_s;
  logic        respawn_r, respawn_s;
  logic        playing_r;
  logic        over_r;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [3:0] ROW = LANE_ROW_BASE + 4'(k);
    frog_collision_ctrl_lane_overlap #(
      .LANE_ROW  (ROW),
      .CAR_WIDTH (CAR_WIDTH)
    ) u_lane (
      .frog_x (bus.i_Frog_X),
      .frog_y (bus.i_Frog_Y),
      .car_x  (bus.i_Car_X[5*k +: 5]),
      .match  (match_s[k])
    );
  end

  // A frog row matches at most one lane, but any number of matches is still a single hit.
  assign overlap_s = |match_s;

`ifdef COLLISION_GRACE_EN
  logic [23:0] grace_r;
  assign grace_active_s = (grace_r != 24'd0);

  // Invulnerability countdown, restarted by every respawn pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      grace_r <= 24'd0;
    end else if (respawn_s) begin
      grace_r <= GRACE_TICKS - 24'd1;
    end else if (grace_active_s) begin
      grace_r <= grace_r - 24'd1;
    end else begin
      grace_r <= grace_r;
    end
  end
`else
  assign grace_active_s = 1'b0;
`endif

  // Next-state, lives, countdown and pulse decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    lives_s   = lives_r;
    hit_s     = 1'b0;
    respawn_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (bus.i_Start) begin
          state_s   = ST_PLAY;
          lives_s   = START_LIVES;
          respawn_s = 1'b1;
        end else begin
          state_s   = state_r;
        end
      end
      ST_PLAY: begin
        if (overlap_s && !grace_active_s) begin
          hit_s   = 1'b1;
          lives_s = (lives_r != 3'd0) ? (lives_r - 3'd1) : 3'd0;
          if (lives_r <= 3'd1) begin
            state_s = ST_OVER;
          end else begin
            state_s = ST_HIT;
            cnt_s   = RESPAWN_TICKS - 24'd1;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_HIT: begin
        if (cnt_r == 24'd0) begin
          state_s   = ST_PLAY;
          respawn_s = 1'b1;
        end else begin
          cnt_s     = cnt_r - 24'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the state being entered.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 24'd0;
      lives_r   <= 3'd0;
      hit_r     <= 1'b0;
      respawn_r <= 1'b0;
      playing_r <= 1'b0;
      over_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      lives_r   <= lives_s;
      hit_r     <= hit_s;
      respawn_r <= respawn_s;
      playing_r <= (state_s == ST_PLAY);
      over_r    <= (state_s == ST_OVER);
    end
  end

  assign bus.o_Hit       = hit_r;
  assign bus.o_Respawn   = respawn_r;
  assign bus.o_Lives     = lives_r;
  assign bus.o_Game_Over = over_r;
  assign bus.o_Playing   = playing_r;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Self-checking bench for frog_collision_ctrl: table vectors, directed corner sequences, random play.
module tb_frog_collision_ctrl;

  localparam int NL = 4;
  localparam int RT = 8;
`ifdef COLLISION_GRACE_EN
  localparam int GW = 6;
`else
  localparam int GW = 0;
`endif

  logic i_Clk   = 1'b0;
  logic i_Rst_n = 1'b0;
  always #5 i_Clk = ~i_Clk;

  frog_collision_ctrl_if #(.NUM_LANES(NL)) bus ();

  frog_collision_ctrl #(
    .NUM_LANES     (NL),
    .RESPAWN_TICKS (24'(RT))
`ifdef COLLISION_GRACE_EN
    ,
    .GRACE_TICKS   (24'(GW))
`endif
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  fx;
    logic [3:0]  fy;
    logic [19:0] cars;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[10];
  int   vectors     = 0;
  int   miscompares = 0;
  int   mlives      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  function automatic logic [19:0] lane_car(input int k, input int x);
    logic [19:0] v;
    v = 20'd0;
    v[5*k +: 5] = 5'(x);
    return v;
  endfunction

  // Reference: enumerate the cells each car occupies and look for the frog among them.
  function automatic bit model_hit(input int fx, input int fy, input logic [19:0] cars);
    for (int k = 0; k < NL; k++) begin
      int cx;
      cx = int'(cars[5*k +: 5]);
      if (fx < 20 && cx < 20 && fy == 3 + k) begin
        for (int c = 0; c < 2; c++) begin
          if ((cx + c) % 20 == fx) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic set_in(input logic [4:0] fx, input logic [3:0] fy, input logic [19:0] cars);
    bus.i_Frog_X = fx;
    bus.i_Frog_Y = fy;
    bus.i_Car_X  = cars;
  endtask

  task automatic safe();
    set_in(5'd0, 4'd0, 20'd0);
  endtask

  task automatic start_pulse(input string tag);
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    mlives = 3;
    chk({tag, "_lives"},   32'(bus.o_Lives), 32'd3);
    chk({tag, "_respawn"}, 32'(bus.o_Respawn), 32'd1);
    chk({tag, "_playing"}, 32'(bus.o_Playing), 32'd1);
    chk({tag, "_over"},    32'(bus.o_Game_Over), 32'd0);
    repeat (GW) step();
  endtask

  task automatic wait_playing(input string tag);
    int n;
    n = 0;
    while (bus.o_Playing !== 1'b1 && n < RT + 4) begin
      step();
      n++;
    end
    chk({tag, "_respawn_wait"},  32'(bus.o_Playing), 32'd1);
    chk({tag, "_respawn_pulse"}, 32'(bus.o_Respawn), 32'd1);
    repeat (GW) step();
  endtask

  // After a checked hit: restart from game over or wait out the respawn delay.
  task automatic recover(input string tag);
    safe();
    if (mlives == 0) begin
      step();
      chk({tag, "_game_over"}, 32'(bus.o_Game_Over), 32'd1);
      start_pulse({tag, "_restart"});
    end else begin
      wait_playing(tag);
    end
  endtask

  task automatic apply(input string tag, input logic [4:0] fx, input logic [3:0] fy,
                       input logic [19:0] cars, input bit exp_hit);
    set_in(fx, fy, cars);
    step();
    if (exp_hit) mlives--;
    chk({tag, "_hit"},   32'(bus.o_Hit), 32'(exp_hit));
    chk({tag, "_lives"}, 32'(bus.o_Lives), 32'(mlives));
    if (exp_hit) recover(tag);
    else safe();
  endtask

  initial begin
    int hits;
    bus.i_Start = 1'b0;
    safe();

    tbl[0] = '{5'd0,  4'd4, lane_car(1, 19), 1'b1};
    tbl[1] = '{5'd0,  4'd4, lane_car(1, 17), 1'b0};
    tbl[2] = '{5'd1,  4'd4, lane_car(1, 19), 1'b0};
    tbl[3] = '{5'd19, 4'd4, lane_car(1, 19), 1'b1};
    tbl[4] = '{5'd20, 4'd3, lane_car(0, 19), 1'b0};
    tbl[5] = '{5'd0,  4'd3, lane_car(0, 20), 1'b0};
    tbl[6] = '{5'd6,  4'd6, lane_car(3, 5),  1'b1};
    tbl[7] = '{5'd6,  4'd7, lane_car(3, 5),  1'b0};
    tbl[8] = '{5'd3,  4'd3, lane_car(0, 4),  1'b0};
    tbl[9] = '{5'd10, 4'd5, lane_car(2, 10), 1'b1};

    // Reset values while held in reset.
    @(negedge i_Clk);
    step();
    chk("rst_lives",   32'(bus.o_Lives), 32'd0);
    chk("rst_hit",     32'(bus.o_Hit), 32'd0);
    chk("rst_respawn", 32'(bus.o_Respawn), 32'd0);
    chk("rst_over",    32'(bus.o_Game_Over), 32'd0);
    chk("rst_playing", 32'(bus.o_Playing), 32'd0);
    i_Rst_n = 1'b1;
    step();
    chk("idle_playing", 32'(bus.o_Playing), 32'd0);
    start_pulse("start");
    step();
    chk("start_respawn_clear", 32'(bus.o_Respawn), 32'd0);

    // Basic hit with full respawn dwell.
    set_in(5'd5, 4'd3, lane_car(0, 4));
    step();
    safe();
    mlives = 2;
    chk("basic_hit",   32'(bus.o_Hit), 32'd1);
    chk("basic_lives", 32'(bus.o_Lives), 32'd2);
    for (int i = 1; i < RT; i++) begin
      step();
      chk("basic_dwell_playing", 32'(bus.o_Playing), 32'd0);
      chk("basic_dwell_hit",     32'(bus.o_Hit), 32'd0);
    end
    step();
    chk("basic_respawn", 32'(bus.o_Respawn), 32'd1);
    chk("basic_playing", 32'(bus.o_Playing), 32'd1);
    repeat (GW) step();

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].fx, tbl[i].fy, tbl[i].cars, tbl[i].exp_hit);
    end

    // Run out of lives, then overlap in game over must be ignored.
    while (mlives > 1) apply("drain", 5'd5, 4'd3, lane_car(0, 4), 1'b1);
    set_in(5'd5, 4'd3, lane_car(0, 4));
    step();
    chk("last_hit",   32'(bus.o_Hit), 32'd1);
    chk("last_lives", 32'(bus.o_Lives), 32'd0);
    mlives = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("over_flag",   32'(bus.o_Game_Over), 32'd1);
      chk("over_no_hit", 32'(bus.o_Hit), 32'd0);
      chk("over_lives",  32'(bus.o_Lives), 32'd0);
      chk("over_playing", 32'(bus.o_Playing), 32'd0);
    end
    safe();
    start_pulse("over_restart");

    // Start ignored in PLAY.
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    chk("play_start_respawn", 32'(bus.o_Respawn), 32'd0);
    chk("play_start_lives",   32'(bus.o_Lives), 32'd3);

    // Overlap held through the HIT state: one hit only; start also ignored there.
    set_in(5'd5, 4'd3, lane_car(0, 4));
    hits = 0;
    for (int i = 0; i < RT - 1; i++) begin
      if (i == 2) bus.i_Start = 1'b1;
      else bus.i_Start = 1'b0;
      step();
      hits += int'(bus.o_Hit);
    end
    bus.i_Start = 1'b0;
    mlives = 2;
    chk("held_hit_count", 32'(hits), 32'd1);
    chk("held_lives",     32'(bus.o_Lives), 32'd2);
    recover("held");

    // Reset asserted mid-HIT returns to idle at once.
    set_in(5'd5, 4'd3, lane_car(0, 4));
    step();
    safe();
    step();
    i_Rst_n = 1'b0;
    #1;
    chk("midhit_rst_lives",   32'(bus.o_Lives), 32'd0);
    chk("midhit_rst_playing", 32'(bus.o_Playing), 32'd0);
    chk("midhit_rst_hit",     32'(bus.o_Hit), 32'd0);
    chk("midhit_rst_over",    32'(bus.o_Game_Over), 32'd0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    step();
    chk("midhit_idle_playing", 32'(bus.o_Playing), 32'd0);
    start_pulse("midhit_restart");

`ifdef COLLISION_GRACE_EN
    // Restart loads grace: overlap masked until the window expires.
    i_Rst_n = 1'b0;
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    step();
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    set_in(5'd5, 4'd3, lane_car(0, 4));
    for (int i = 1; i < GW; i++) begin
      step();
      chk("grace_masked", 32'(bus.o_Hit), 32'd0);
      chk("grace_playing", 32'(bus.o_Playing), 32'd1);
    end
    step();
    chk("grace_expired_hit", 32'(bus.o_Hit), 32'd1);
    mlives = 2;
    recover("grace");
`endif

    // Random play against the reference model.
    for (int it = 0; it < 300; it++) begin
      int fx, fy, k;
      logic [19:0] cars;
      cars = 20'd0;
      for (int l = 0; l < NL; l++) cars[5*l +: 5] = 5'($urandom_range(0, 21));
      fx = int'($urandom_range(0, 21));
      if ($urandom_range(0, 1) == 0) begin
        k  = int'($urandom_range(0, NL - 1));
        fy = 3 + k;
        cars[5*k +: 5] = 5'((fx + 20 - int'($urandom_range(0, 3))) % 20);
      end else begin
        fy = int'($urandom_range(0, 14));
      end
      apply("rand", 5'(fx), 4'(fy), cars, model_hit(fx, fy, cars));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
